// File: rtl/glm_load_pkg.sv
// rtl/glm_load_pkg.sv - shared types, register indices and CCI-P c0 structures for the load stage
package glm_load_pkg;
  localparam int LINE_CNT_W   = 16;
  localparam int BRAM_ADDR_W  = 16;
  localparam int NUM_CHANNELS = 2;
  localparam int NUM_REGS     = 4;
  localparam int CL_ADDR_W    = 42;
  localparam int CL_DATA_W    = 512;
  localparam int CH_SEL_W     = 4;

  localparam int LOAD_OFFSET_REG = 0;
  localparam int LOAD_LENGTH_REG = 1;
  localparam int LOAD_BRAM_REG   = 2;
  localparam int CH_MODEL        = 0;
  localparam int CH_LABELS       = 1;

  localparam logic [3:0] REQ_RDLINE_I = 4'h0;
  localparam logic [1:0] CL_LEN_1     = 2'b00;
  localparam logic [3:0] RSP_RDLINE   = 4'h0;

  typedef enum logic [1:0] {IDLE, READ, DONE} t_loadstate;

  typedef logic [CL_ADDR_W-1:0] t_ccip_clAddr;
  typedef logic [CL_DATA_W-1:0] t_ccip_clData;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    logic [1:0]   cl_len;
    logic [3:0]   req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  // Bit 31 of the offset register picks the output buffer instead of the input buffer.
  function automatic t_ccip_clAddr load_base(input logic [31:0] offset_reg,
                                             input t_ccip_clAddr in_addr,
                                             input t_ccip_clAddr out_addr);
    return (offset_reg[31] ? out_addr : in_addr) + t_ccip_clAddr'(offset_reg[30:0]);
  endfunction
endpackage

// File: rtl/glm_load_bram_demux.sv
// rtl/glm_load_bram_demux.sv - registered steering of one BRAM write onto the selected channel
module glm_load_bram_demux
  import glm_load_pkg::*;
(
  input  logic                                     i_clk,
  input  logic                                     i_reset_n,
  input  logic                                     i_we,
  input  logic [BRAM_ADDR_W-1:0]                   i_waddr,
  input  t_ccip_clData                             i_wdata,
  input  logic [CH_SEL_W-1:0]                      i_channel,
  output logic [NUM_CHANNELS-1:0]                  o_we,
  output logic [NUM_CHANNELS-1:0][BRAM_ADDR_W-1:0] o_waddr,
  output logic [NUM_CHANNELS-1:0][CL_DATA_W-1:0]   o_wdata
);
  // An out-of-range channel matches no port, so the write is silently dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_we    <= '0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        o_we[c] <= i_we && (i_channel == CH_SEL_W'(c));
        if (i_we && (i_channel == CH_SEL_W'(c))) begin
          o_waddr[c] <= i_waddr;
          o_wdata[c] <= i_wdata;
        end
      end
    end
  end
endmodule

// File: rtl/glm_load.sv
// rtl/glm_load.sv - reads a run of cache lines over CCI-P c0 and writes them into a BRAM channel
module glm_load
  import glm_load_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_op_start,
  output logic                      o_op_done,
  input  logic [NUM_REGS-1:0][31:0] i_regs,
  input  t_ccip_clAddr              i_in_addr,
  input  t_ccip_clAddr              i_out_addr,
  output logic                      o_mem_model_we,
  output logic [BRAM_ADDR_W-1:0]    o_mem_model_waddr,
  output t_ccip_clData              o_mem_model_wdata,
  output logic                      o_mem_labels_we,
  output logic [BRAM_ADDR_W-1:0]    o_mem_labels_waddr,
  output t_ccip_clData              o_mem_labels_wdata,
  input  logic                      i_c0_tx_alm_full,
  input  t_if_ccip_c0_Rx            i_c0_rx,
  output t_if_ccip_c0_Tx            o_c0_tx
);
  t_loadstate              r_state;
  t_ccip_clAddr            r_base;
  logic [LINE_CNT_W-1:0]   r_length;
  logic [LINE_CNT_W-1:0]   r_num_req;
  logic [LINE_CNT_W-1:0]   r_num_rsp;
  logic [BRAM_ADDR_W-1:0]  r_bram_base;
  logic [CH_SEL_W-1:0]     r_channel;

  logic                                     w_wr_en;
  logic                                     w_issue;
  logic [BRAM_ADDR_W-1:0]                   w_waddr;
  logic [NUM_CHANNELS-1:0]                  w_we;
  logic [NUM_CHANNELS-1:0][BRAM_ADDR_W-1:0] w_waddr_ch;
  logic [NUM_CHANNELS-1:0][CL_DATA_W-1:0]   w_wdata_ch;
  logic                                     w_unused;

  // Responses only count in READ, so stale tags after a reset or a finished run are dropped.
  assign w_wr_en = (r_state == READ) && i_c0_rx.rspValid && (i_c0_rx.hdr.resp_type == RSP_RDLINE);
  assign w_issue = (r_state == READ) && (r_num_req < r_length) && !i_c0_tx_alm_full;
  assign w_waddr = r_bram_base + BRAM_ADDR_W'(i_c0_rx.hdr.mdata);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_length    <= '0;
      r_num_req   <= '0;
      r_num_rsp   <= '0;
      r_bram_base <= '0;
      r_channel   <= '0;
      o_c0_tx     <= '0;
      o_op_done   <= 1'b0;
    end else begin
      o_c0_tx   <= '0;
      o_op_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_op_start) begin
            r_base      <= load_base(i_regs[LOAD_OFFSET_REG], i_in_addr, i_out_addr);
            r_length    <= i_regs[LOAD_LENGTH_REG][LINE_CNT_W-1:0];
            r_bram_base <= i_regs[LOAD_BRAM_REG][BRAM_ADDR_W-1:0];
            r_channel   <= i_regs[LOAD_BRAM_REG][16 +: CH_SEL_W];
            r_num_req   <= '0;
            r_num_rsp   <= '0;
            r_state     <= (i_regs[LOAD_LENGTH_REG][LINE_CNT_W-1:0] == '0) ? DONE : READ;
          end
        end
        READ: begin
          if (w_issue) begin
            o_c0_tx.valid        <= 1'b1;
            o_c0_tx.hdr.req_type <= REQ_RDLINE_I;
            o_c0_tx.hdr.cl_len   <= CL_LEN_1;
            o_c0_tx.hdr.address  <= r_base + t_ccip_clAddr'(r_num_req);
            o_c0_tx.hdr.mdata    <= r_num_req;
            r_num_req            <= r_num_req + LINE_CNT_W'(1);
          end
          if (w_wr_en) begin
            r_num_rsp <= r_num_rsp + LINE_CNT_W'(1);
            if (r_num_rsp == r_length - LINE_CNT_W'(1)) r_state <= DONE;
          end
        end
        DONE: begin
          o_op_done <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  glm_load_bram_demux u_bram_demux (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_we      (w_wr_en),
    .i_waddr   (w_waddr),
    .i_wdata   (i_c0_rx.data),
    .i_channel (r_channel),
    .o_we      (w_we),
    .o_waddr   (w_waddr_ch),
    .o_wdata   (w_wdata_ch)
  );

  assign o_mem_model_we     = w_we[CH_MODEL];
  assign o_mem_model_waddr  = w_waddr_ch[CH_MODEL];
  assign o_mem_model_wdata  = w_wdata_ch[CH_MODEL];
  assign o_mem_labels_we    = w_we[CH_LABELS];
  assign o_mem_labels_waddr = w_waddr_ch[CH_LABELS];
  assign o_mem_labels_wdata = w_wdata_ch[CH_LABELS];

  assign w_unused = ^{i_regs[3], i_regs[1][31:16], i_regs[2][31:20], i_c0_rx.hdr.vc_used,
                      i_c0_rx.hdr.rsvd1, i_c0_rx.hdr.hit_miss, i_c0_rx.hdr.rsvd0,
                      i_c0_rx.hdr.cl_num, i_c0_rx.mmioRdValid, i_c0_rx.mmioWrValid};
endmodule
